// File: rtl/avalon_flit_bridge_mc_pkg.sv
// Shared definitions for the multi-channel Avalon-MM flit bridge:
// register map, STATUS bit positions, CLEAR command bits and the drop-counter ceiling.
package avalon_flit_bridge_mc_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_TX_DATA = 3'd1;
  localparam logic [2:0] REG_RX_DATA = 3'd2;
  localparam logic [2:0] REG_IRQ_EN  = 3'd3;
  localparam logic [2:0] REG_CH_SEL  = 3'd4;
  localparam logic [2:0] REG_COUNT   = 3'd5;
  localparam logic [2:0] REG_DROPS   = 3'd6;
  localparam logic [2:0] REG_CLEAR   = 3'd7;

  localparam int STAT_RX_NE_LSB = 0;
  localparam int STAT_TX_NF_LSB = 8;
  localparam int STAT_UNDERFLOW = 16;
  localparam int STAT_OVERFLOW  = 17;

  localparam int CLEAR_STICKY_BIT = 0;
  localparam int CLEAR_FLUSH_BIT  = 1;

  localparam logic [15:0] DROPS_MAX = 16'hFFFF;

endpackage

// File: rtl/avalon_flit_bridge_mc_flit_fifo.sv
// Synchronous FIFO with push, pop and flush; the head reads as zero while empty.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module flit_fifo
  import avalon_flit_bridge_mc_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enq,
  input  logic [W-1:0]             enq_data,
  input  logic                     deq,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          do_enq;
  logic          do_deq;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;
  assign head  = empty ? '0 : mem[rd_ptr];

  // Pops only see stored data (no bypass); flush overrides both sides.
  assign do_deq = deq && !empty && !flush;
  assign do_enq = enq && (!full || do_deq) && !flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_deq) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_enq && !do_deq)      cnt <= cnt + CNT_ONE;
      else if (!do_enq && do_deq) cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/avalon_flit_bridge_mc.sv
// Multi-channel Avalon-MM slave between the Nios CPU and the flit core:
// per-channel TX/RX FIFOs, channel select, status/occupancy readback, maskable IRQ, drop counter.
module avalon_flit_bridge_mc
  import avalon_flit_bridge_mc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int FLIT_W   = 32,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [2:0]                 avs_address,
  input  logic                       avs_read,
  output logic [31:0]                avs_readdata,
  output logic                       avs_readdatavalid,
  input  logic                       avs_write,
  input  logic [31:0]                avs_writedata,
  output logic                       irq,
  output logic [NUM_CH*FLIT_W-1:0]   deq_flit,
  output logic [NUM_CH-1:0]          RDY_deq_flit,
  input  logic [NUM_CH-1:0]          EN_deq_flit,
  input  logic [NUM_CH*FLIT_W-1:0]   enq_flit,
  input  logic [NUM_CH-1:0]          EN_enq_flit,
  output logic [NUM_CH-1:0]          RDY_enq_flit
);

  localparam int TXC = $clog2(TX_DEPTH) + 1;
  localparam int RXC = $clog2(RX_DEPTH) + 1;

  logic [NUM_CH-1:0] tx_full, tx_empty, rx_full, rx_empty;
  logic [NUM_CH-1:0] tx_enq, rx_deq, flush, sel_mask;
  logic [TXC-1:0]    tx_count [NUM_CH];
  logic [RXC-1:0]    rx_count [NUM_CH];
  logic [FLIT_W-1:0] rx_head  [NUM_CH];

  logic [2:0]        ch_sel;
  logic [NUM_CH-1:0] irq_en;
  logic [15:0]       drops;
  logic              underflow, overflow;

  logic              rd_acc, wr_acc, tx_push_req, rx_pop_req, tx_drop;
  logic [FLIT_W-1:0] sel_rx_head;
  logic              sel_rx_empty, sel_tx_full, sel_core_deq;
  logic [TXC-1:0]    sel_tx_count;
  logic [RXC-1:0]    sel_rx_count;
  logic [31:0]       rd_mux;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flit_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx (
      .CLK      (CLK),
      .RST      (RST),
      .enq      (tx_enq[i]),
      .enq_data (avs_writedata[FLIT_W-1:0]),
      .deq      (EN_deq_flit[i]),
      .flush    (flush[i]),
      .head     (deq_flit[i*FLIT_W +: FLIT_W]),
      .full     (tx_full[i]),
      .empty    (tx_empty[i]),
      .count    (tx_count[i])
    );
    flit_fifo #(.W(FLIT_W), .DEPTH(RX_DEPTH)) u_rx (
      .CLK      (CLK),
      .RST      (RST),
      .enq      (EN_enq_flit[i]),
      .enq_data (enq_flit[i*FLIT_W +: FLIT_W]),
      .deq      (rx_deq[i]),
      .flush    (flush[i]),
      .head     (rx_head[i]),
      .full     (rx_full[i]),
      .empty    (rx_empty[i]),
      .count    (rx_count[i])
    );
  end

  assign RDY_deq_flit = ~tx_empty;
  assign RDY_enq_flit = ~rx_full;

  // A simultaneous read and write is treated as a read only.
  assign rd_acc = avs_read;
  assign wr_acc = avs_write && !avs_read;

  always_comb begin
    sel_mask     = '0;
    sel_rx_head  = '0;
    sel_rx_empty = 1'b1;
    sel_tx_full  = 1'b0;
    sel_core_deq = 1'b0;
    sel_tx_count = '0;
    sel_rx_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) begin
        sel_mask[i]  = 1'b1;
        sel_rx_head  = rx_head[i];
        sel_rx_empty = rx_empty[i];
        sel_tx_full  = tx_full[i];
        sel_core_deq = EN_deq_flit[i];
        sel_tx_count = tx_count[i];
        sel_rx_count = rx_count[i];
      end
    end
  end

  assign tx_push_req = wr_acc && (avs_address == REG_TX_DATA);
  assign rx_pop_req  = rd_acc && (avs_address == REG_RX_DATA);
  assign tx_enq      = tx_push_req ? sel_mask : '0;
  assign rx_deq      = rx_pop_req  ? sel_mask : '0;
  assign flush       = (wr_acc && (avs_address == REG_CLEAR) && avs_writedata[CLEAR_FLUSH_BIT])
                       ? sel_mask : '0;
  // A full TX FIFO still takes the write when the core drains it in the same cycle.
  assign tx_drop     = tx_push_req && sel_tx_full && !sel_core_deq;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_STATUS: begin
        rd_mux[STAT_RX_NE_LSB +: NUM_CH] = ~rx_empty;
        rd_mux[STAT_TX_NF_LSB +: NUM_CH] = ~tx_full;
        rd_mux[STAT_UNDERFLOW]           = underflow;
        rd_mux[STAT_OVERFLOW]            = overflow;
      end
      REG_RX_DATA: rd_mux[FLIT_W-1:0] = sel_rx_head;
      REG_IRQ_EN:  rd_mux[NUM_CH-1:0] = irq_en;
      REG_CH_SEL:  rd_mux[2:0]        = ch_sel;
      REG_COUNT: begin
        rd_mux[7:0]  = 8'(sel_rx_count);
        rd_mux[15:8] = 8'(sel_tx_count);
      end
      REG_DROPS:   rd_mux[15:0]       = drops;
      default:     rd_mux             = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ch_sel    <= '0;
      irq_en    <= '0;
      drops     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_acc) begin
        case (avs_address)
          REG_IRQ_EN: irq_en <= avs_writedata[NUM_CH-1:0];
          REG_CH_SEL: if (avs_writedata < 32'(NUM_CH)) ch_sel <= avs_writedata[2:0];
          REG_DROPS:  drops <= '0;
          REG_CLEAR: begin
            if (avs_writedata[CLEAR_STICKY_BIT]) begin
              underflow <= 1'b0;
              overflow  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (tx_drop) begin
        overflow <= 1'b1;
        if (drops != DROPS_MAX) drops <= drops + 16'd1;
      end
      if (rx_pop_req && sel_rx_empty) underflow <= 1'b1;
      irq <= |(~rx_empty & irq_en);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_acc;
      if (rd_acc) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avalon_flit_bridge_mc.sv
// Self-checking bench for avalon_flit_bridge_mc: directed scenarios plus a randomized run
// against a queue-based reference model of the register map and per-channel FIFOs.
module tb_avalon_flit_bridge_mc;

  localparam int NUM_CH = 4;
  localparam int FLIT_W = 32;
  localparam int DEPTH  = 8;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic [2:0]               avs_address = '0;
  logic                     avs_read = 1'b0;
  logic [31:0]              avs_readdata;
  logic                     avs_readdatavalid;
  logic                     avs_write = 1'b0;
  logic [31:0]              avs_writedata = '0;
  logic                     irq;
  logic [NUM_CH*FLIT_W-1:0] deq_flit;
  logic [NUM_CH-1:0]        RDY_deq_flit;
  logic [NUM_CH-1:0]        EN_deq_flit = '0;
  logic [NUM_CH*FLIT_W-1:0] enq_flit = '0;
  logic [NUM_CH-1:0]        EN_enq_flit = '0;
  logic [NUM_CH-1:0]        RDY_enq_flit;

  int errors = 0;
  int checks = 0;

  logic [31:0]       tx_q [NUM_CH][$];
  logic [31:0]       rx_q [NUM_CH][$];
  int                m_sel;
  logic [NUM_CH-1:0] m_irq_en;
  int                m_drops;
  bit                m_unf, m_ovf;
  logic [31:0]       exp_rdata;
  bit                exp_valid, exp_check, exp_irq;

  avalon_flit_bridge_mc #(.NUM_CH(NUM_CH), .FLIT_W(FLIT_W), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .irq               (irq),
    .deq_flit          (deq_flit),
    .RDY_deq_flit      (RDY_deq_flit),
    .EN_deq_flit       (EN_deq_flit),
    .enq_flit          (enq_flit),
    .EN_enq_flit       (EN_enq_flit),
    .RDY_enq_flit      (RDY_enq_flit)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      tx_q[i].delete();
      rx_q[i].delete();
    end
    m_sel = 0; m_irq_en = '0; m_drops = 0; m_unf = 0; m_ovf = 0;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0;
    EN_deq_flit = '0; EN_enq_flit = '0; enq_flit = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  // Drives one bus/core cycle starting at a falling edge and advances the model from pre-edge state.
  task automatic do_cycle(input bit rd, input bit wr, input logic [2:0] addr, input logic [31:0] data,
                          input logic [NUM_CH-1:0] en_deq, input logic [NUM_CH-1:0] en_enq,
                          input logic [NUM_CH*FLIT_W-1:0] edata);
    bit wr_eff, set_unf, core_pop, push, fl, cpu_pop;
    int rx_pre;
    logic [31:0] st;
    avs_read = rd; avs_write = wr; avs_address = addr; avs_writedata = data;
    EN_deq_flit = en_deq; EN_enq_flit = en_enq; enq_flit = edata;
    wr_eff = wr && !rd;
    set_unf = 0;
    exp_valid = rd;
    exp_check = rd && (addr != 3'd1) && (addr != 3'd7);
    exp_irq = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (rx_q[i].size() > 0 && m_irq_en[i]) exp_irq = 1;
    if (rd) begin
      exp_rdata = '0;
      case (addr)
        3'd0: begin
          st = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            st[i]     = rx_q[i].size() != 0;
            st[8 + i] = tx_q[i].size() < DEPTH;
          end
          st[16] = m_unf; st[17] = m_ovf;
          exp_rdata = st;
        end
        3'd2: begin
          if (rx_q[m_sel].size() > 0) exp_rdata = rx_q[m_sel][0];
          else set_unf = 1;
        end
        3'd3: exp_rdata = 32'(m_irq_en);
        3'd4: exp_rdata = 32'(m_sel);
        3'd5: exp_rdata = {16'd0, 8'(tx_q[m_sel].size()), 8'(rx_q[m_sel].size())};
        3'd6: exp_rdata = 32'(m_drops);
        default: exp_rdata = '0;
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      fl = wr_eff && addr == 3'd7 && data[1] && i == m_sel;
      if (fl) begin
        tx_q[i].delete();
        rx_q[i].delete();
      end else begin
        core_pop = en_deq[i] && tx_q[i].size() > 0;
        push = wr_eff && addr == 3'd1 && i == m_sel;
        if (push && !(tx_q[i].size() < DEPTH || core_pop)) begin
          push = 0;
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        if (core_pop) void'(tx_q[i].pop_front());
        if (push) tx_q[i].push_back(data);
        rx_pre = rx_q[i].size();
        cpu_pop = rd && addr == 3'd2 && i == m_sel && rx_pre > 0;
        if (cpu_pop) void'(rx_q[i].pop_front());
        if (en_enq[i] && (rx_pre < DEPTH || cpu_pop)) rx_q[i].push_back(edata[i*FLIT_W +: FLIT_W]);
      end
    end
    if (wr_eff) begin
      case (addr)
        3'd3: m_irq_en = data[NUM_CH-1:0];
        3'd4: if (data < NUM_CH) m_sel = int'(data);
        3'd6: m_drops = 0;
        3'd7: if (data[0]) begin m_unf = 0; m_ovf = 0; end
        default: ;
      endcase
    end
    if (set_unf) m_unf = 1;
    @(negedge CLK);
    avs_read = 0; avs_write = 0; EN_deq_flit = '0; EN_enq_flit = '0;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
    do_cycle(0, 1, addr, data, '0, '0, '0);
  endtask

  task automatic read_reg(input logic [2:0] addr, output logic [31:0] data, output logic valid);
    do_cycle(1, 0, addr, '0, '0, '0, '0);
    data = avs_readdata;
    valid = avs_readdatavalid;
  endtask

  task automatic idle();
    do_cycle(0, 0, 3'd0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    reset_dut();
    checks++; if (avs_readdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_readdata: got %h expected 0", avs_readdata); end
    checks++; if (avs_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", avs_readdatavalid); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (RDY_deq_flit !== 4'h0) begin errors++; $display("[TB] FAIL reset_rdy_deq: got %h expected 0", RDY_deq_flit); end
    checks++; if (RDY_enq_flit !== 4'hF) begin errors++; $display("[TB] FAIL reset_rdy_enq: got %h expected f", RDY_enq_flit); end
    checks++; if (deq_flit !== '0) begin errors++; $display("[TB] FAIL reset_deq_flit: got %h expected 0", deq_flit); end
    read_reg(3'd0, d, v);
    checks++; if (v !== 1'b1) begin errors++; $display("[TB] FAIL status_valid: got %b expected 1", v); end
    checks++; if (d !== 32'h0000_0F00) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000f00", d); end
    idle();
    checks++; if (avs_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL valid_single_cycle: got %b expected 0", avs_readdatavalid); end
  endtask

  task automatic test_tx_path();
    reset_dut();
    write_reg(3'd4, 32'd2);
    write_reg(3'd1, 32'hA5A5_0001);
    checks++; if (RDY_deq_flit !== 4'b0100) begin errors++; $display("[TB] FAIL tx_rdy: got %b expected 0100", RDY_deq_flit); end
    checks++; if (deq_flit[2*FLIT_W +: FLIT_W] !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL tx_head_ch2: got %h expected a5a50001", deq_flit[2*FLIT_W +: FLIT_W]); end
    do_cycle(0, 0, 3'd0, '0, 4'b0100, '0, '0);
    checks++; if (RDY_deq_flit !== 4'b0000) begin errors++; $display("[TB] FAIL tx_rdy_after_pop: got %b expected 0000", RDY_deq_flit); end
    checks++; if (deq_flit !== '0) begin errors++; $display("[TB] FAIL tx_head_after_pop: got %h expected 0", deq_flit); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d; logic v;
    reset_dut();
    for (int i = 0; i < 9; i++) write_reg(3'd1, 32'h100 + i);
    read_reg(3'd6, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("[TB] FAIL ovf_drops: got %h expected 1", d); end
    read_reg(3'd0, d, v);
    checks++; if (d !== 32'h0002_0E00) begin errors++; $display("[TB] FAIL ovf_status: got %h expected 00020e00", d); end
    read_reg(3'd5, d, v);
    checks++; if (d !== 32'h0000_0800) begin errors++; $display("[TB] FAIL ovf_count: got %h expected 00000800", d); end
    checks++; if (deq_flit[FLIT_W-1:0] !== 32'h100) begin errors++; $display("[TB] FAIL ovf_head: got %h expected 100", deq_flit[FLIT_W-1:0]); end
    write_reg(3'd6, 32'd0);
    read_reg(3'd6, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL drops_clear: got %h expected 0", d); end
  endtask

  task automatic test_rx_irq();
    logic [31:0] d; logic v;
    logic [NUM_CH*FLIT_W-1:0] ed;
    reset_dut();
    write_reg(3'd3, 32'h2);
    ed = '0; ed[0 +: FLIT_W] = 32'hDEAD;
    do_cycle(0, 0, 3'd0, '0, '0, 4'b0001, ed);
    idle();
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked: got %b expected 0", irq); end
    ed = '0; ed[FLIT_W +: FLIT_W] = 32'h1234;
    do_cycle(0, 0, 3'd0, '0, '0, 4'b0010, ed);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_lag: got %b expected 0", irq); end
    idle();
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set: got %b expected 1", irq); end
    write_reg(3'd4, 32'd1);
    read_reg(3'd2, d, v);
    checks++; if (d !== 32'h1234) begin errors++; $display("[TB] FAIL rx_data: got %h expected 1234", d); end
    idle();
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_underflow();
    logic [31:0] d; logic v;
    reset_dut();
    read_reg(3'd2, d, v);
    checks++; if (d !== 32'd0 || v !== 1'b1) begin errors++; $display("[TB] FAIL unf_data: got %h/%b expected 0/1", d, v); end
    read_reg(3'd0, d, v);
    checks++; if (d !== 32'h0001_0F00) begin errors++; $display("[TB] FAIL unf_status: got %h expected 00010f00", d); end
    write_reg(3'd7, 32'd1);
    read_reg(3'd0, d, v);
    checks++; if (d !== 32'h0000_0F00) begin errors++; $display("[TB] FAIL unf_cleared: got %h expected 00000f00", d); end
  endtask

  task automatic test_full_simultaneous();
    logic [31:0] d; logic v;
    reset_dut();
    for (int i = 0; i < 8; i++) write_reg(3'd1, 32'h10 + i);
    do_cycle(0, 1, 3'd1, 32'h99, 4'b0001, '0, '0);
    read_reg(3'd5, d, v);
    checks++; if (d !== 32'h0000_0800) begin errors++; $display("[TB] FAIL simul_count: got %h expected 00000800", d); end
    read_reg(3'd6, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL simul_drops: got %h expected 0", d); end
    checks++; if (deq_flit[FLIT_W-1:0] !== 32'h11) begin errors++; $display("[TB] FAIL simul_head: got %h expected 11", deq_flit[FLIT_W-1:0]); end
    read_reg(3'd0, d, v);
    checks++; if (d !== 32'h0000_0E00) begin errors++; $display("[TB] FAIL simul_status: got %h expected 00000e00", d); end
  endtask

  task automatic test_flush_and_select();
    logic [31:0] d; logic v;
    logic [NUM_CH*FLIT_W-1:0] ed;
    reset_dut();
    write_reg(3'd1, 32'h1);
    write_reg(3'd1, 32'h2);
    ed = '0; ed[0 +: FLIT_W] = 32'h77;
    do_cycle(0, 0, 3'd0, '0, '0, 4'b0001, ed);
    do_cycle(0, 1, 3'd7, 32'h2, 4'b0001, 4'b0001, ed);
    checks++; if (RDY_deq_flit !== 4'b0000) begin errors++; $display("[TB] FAIL flush_rdy_deq: got %b expected 0000", RDY_deq_flit); end
    read_reg(3'd5, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL flush_count: got %h expected 0", d); end
    do_cycle(1, 1, 3'd4, 32'd3, '0, '0, '0);
    checks++; if (avs_readdata !== 32'd0) begin errors++; $display("[TB] FAIL rdwr_read: got %h expected 0", avs_readdata); end
    read_reg(3'd4, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL rdwr_ignored: got %h expected 0", d); end
    write_reg(3'd4, 32'd5);
    read_reg(3'd4, d, v);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL chsel_invalid: got %h expected 0", d); end
    write_reg(3'd4, 32'd3);
    read_reg(3'd4, d, v);
    checks++; if (d !== 32'd3) begin errors++; $display("[TB] FAIL chsel_valid: got %h expected 3", d); end
  endtask

  task automatic test_reset_midread();
    reset_dut();
    write_reg(3'd1, 32'h55);
    avs_read = 1'b1; avs_address = 3'd0;
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    avs_read = 1'b0;
    checks++; if (avs_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL midread_valid: got %b expected 0", avs_readdatavalid); end
    checks++; if (RDY_deq_flit !== 4'h0) begin errors++; $display("[TB] FAIL midread_fifo: got %b expected 0000", RDY_deq_flit); end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    idle();
    checks++; if (avs_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL midread_no_late_valid: got %b expected 0", avs_readdatavalid); end
  endtask

  task automatic test_random();
    bit rd, wr;
    logic [2:0] addr;
    logic [31:0] data;
    logic [NUM_CH-1:0] en_deq, en_enq, exp_rdy_deq, exp_rdy_enq;
    logic [NUM_CH*FLIT_W-1:0] ed, exp_flits;
    int a;
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 1) == 0);
      a = $urandom_range(0, 11);
      addr = (a > 9) ? 3'd2 : (a > 7) ? 3'd1 : 3'(a);
      data = $urandom;
      if (addr == 3'd4) data = $urandom_range(0, 7);
      if (addr == 3'd7) data = $urandom_range(0, 3);
      for (int i = 0; i < NUM_CH; i++) begin
        en_deq[i] = ($urandom_range(0, 3) == 0);
        en_enq[i] = ($urandom_range(0, 2) == 0) && (rx_q[i].size() < DEPTH);
        ed[i*FLIT_W +: FLIT_W] = $urandom;
      end
      do_cycle(rd, wr, addr, data, en_deq, en_enq, ed);
      exp_rdy_deq = '0; exp_rdy_enq = '0; exp_flits = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (tx_q[i].size() > 0) begin
          exp_rdy_deq[i] = 1'b1;
          exp_flits[i*FLIT_W +: FLIT_W] = tx_q[i][0];
        end
        exp_rdy_enq[i] = rx_q[i].size() < DEPTH;
      end
      checks++; if (avs_readdatavalid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid cyc %0d: got %b expected %b", n, avs_readdatavalid, exp_valid); end
      if (exp_check) begin
        checks++; if (avs_readdata !== exp_rdata) begin errors++; $display("[TB] FAIL rnd_rdata cyc %0d addr %0d: got %h expected %h", n, addr, avs_readdata, exp_rdata); end
      end
      checks++; if (irq !== exp_irq) begin errors++; $display("[TB] FAIL rnd_irq cyc %0d: got %b expected %b", n, irq, exp_irq); end
      checks++; if (RDY_deq_flit !== exp_rdy_deq) begin errors++; $display("[TB] FAIL rnd_rdy_deq cyc %0d: got %b expected %b", n, RDY_deq_flit, exp_rdy_deq); end
      checks++; if (RDY_enq_flit !== exp_rdy_enq) begin errors++; $display("[TB] FAIL rnd_rdy_enq cyc %0d: got %b expected %b", n, RDY_enq_flit, exp_rdy_enq); end
      checks++; if (deq_flit !== exp_flits) begin errors++; $display("[TB] FAIL rnd_deq_flit cyc %0d: got %h expected %h", n, deq_flit, exp_flits); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tx_path();
    test_tx_overflow();
    test_rx_irq();
    test_underflow();
    test_full_simultaneous();
    test_flush_and_select();
    test_reset_midread();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
